// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged per-subsystem reset release driven by a synchronised reset request
module reset_sequencer #(
    parameter int NUM_STAGES    = 4,
    parameter int STAGE_DELAY   = 16,
    parameter int READY_TIMEOUT = 1024,
    parameter int SYNC_STAGES   = 2,
    localparam int FW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rst_req_n,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_reset_n,
    output logic                  seq_done,
    output logic                  fault,
    output logic [FW-1:0]         fault_stage
);
    localparam int CW = $clog2(STAGE_DELAY + 1);
    localparam int TW = $clog2(READY_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STAGE_DELAY - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(READY_TIMEOUT - 1);
    localparam logic [FW-1:0] CUR_LAST = FW'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_DELAY,
        S_WAIT_RDY,
        S_DONE,
        S_FAULT
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [FW-1:0]           cur_q, cur_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [NUM_STAGES-1:0]   stage_reset_n_q, stage_reset_n_d;
    logic                    seq_done_q, seq_done_d;
    logic                    fault_q, fault_d;
    logic [FW-1:0]           fault_stage_q, fault_stage_d;
    logic                    req_s;
    logic [NUM_STAGES-1:0]   cur_bit;

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign cur_bit = NUM_STAGES'(1) << cur_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rst_req_n};
    end

    always_comb begin
        state_d         = state_q;
        cur_d           = cur_q;
        cnt_d           = cnt_q;
        tmo_d           = tmo_q;
        stage_reset_n_d = stage_reset_n_q;
        seq_done_d      = seq_done_q;
        fault_d         = fault_q;
        fault_stage_d   = fault_stage_q;

        // A dropped request aborts whatever is in progress and always restarts from stage 0.
        if (!req_s) begin
            state_d         = S_HOLD;
            cur_d           = '0;
            cnt_d           = '0;
            tmo_d           = '0;
            stage_reset_n_d = '0;
            seq_done_d      = 1'b0;
            fault_d         = 1'b0;
            fault_stage_d   = '0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    state_d         = S_DELAY;
                    cur_d           = '0;
                    cnt_d           = '0;
                    stage_reset_n_d = '0;
                end
                S_DELAY: begin
                    if (cnt_q >= CNT_LAST) begin
                        stage_reset_n_d = stage_reset_n_q | cur_bit;
                        state_d         = S_WAIT_RDY;
                        tmo_d           = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_RDY: begin
                    // Ready is checked before the timeout so a same-edge ready still advances.
                    if (stage_ready[cur_q]) begin
                        if (cur_q == CUR_LAST) begin
                            state_d         = S_DONE;
                            seq_done_d      = 1'b1;
                            stage_reset_n_d = '1;
                        end else begin
                            cur_d   = cur_q + 1'b1;
                            cnt_d   = '0;
                            state_d = S_DELAY;
                        end
                    end else if (tmo_q >= TMO_LAST) begin
                        state_d         = S_FAULT;
                        fault_d         = 1'b1;
                        fault_stage_d   = cur_q;
                        stage_reset_n_d = '0;
                        seq_done_d      = 1'b0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                S_DONE: begin
                    stage_reset_n_d = '1;
                    seq_done_d      = 1'b1;
                end
                S_FAULT: begin
                    stage_reset_n_d = '0;
                    seq_done_d      = 1'b0;
                    fault_d         = 1'b1;
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_HOLD;
            sync_q          <= '0;
            cur_q           <= '0;
            cnt_q           <= '0;
            tmo_q           <= '0;
            stage_reset_n_q <= '0;
            seq_done_q      <= 1'b0;
            fault_q         <= 1'b0;
            fault_stage_q   <= '0;
        end else begin
            state_q         <= state_d;
            sync_q          <= sync_d;
            cur_q           <= cur_d;
            cnt_q           <= cnt_d;
            tmo_q           <= tmo_d;
            stage_reset_n_q <= stage_reset_n_d;
            seq_done_q      <= seq_done_d;
            fault_q         <= fault_d;
            fault_stage_q   <= fault_stage_d;
        end
    end

    assign stage_reset_n = stage_reset_n_q;
    assign seq_done      = seq_done_q;
    assign fault         = fault_q;
    assign fault_stage   = fault_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer output-change events
module tb_reset_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       rst_req_n;
    logic [3:0] stage_ready;
    logic [3:0] stage_reset_n;
    logic       seq_done;
    logic       fault;
    logic [1:0] fault_stage;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mode  = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } ev_t;
    ev_t exp_q[$];

    logic [3:0] dl [0:4];
    logic [7:0] obs;
    assign obs = {stage_reset_n, seq_done, fault, fault_stage};

    reset_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .rst_req_n     (rst_req_n),
        .stage_ready   (stage_ready),
        .stage_reset_n (stage_reset_n),
        .seq_done      (seq_done),
        .fault         (fault),
        .fault_stage   (fault_stage)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // mode 0: ready = reset_n delayed 5 cycles; 1: all ready; 2: as 0 but stage 2 never ready
    initial begin
        for (int i = 0; i < 5; i++) dl[i] = 4'b0000;
        stage_ready = 4'b0000;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       stage_ready = dl[4];
                1:       stage_ready = 4'b1111;
                default: stage_ready = dl[4] & 4'b1011;
            endcase
            for (int i = 4; i > 0; i--) dl[i] = dl[i-1];
            dl[0] = stage_reset_n;
        end
    end

    function automatic logic [7:0] mk(logic [3:0] s, logic d, logic f, logic [1:0] fs);
        return {s, d, f, fs};
    endfunction

    task automatic push(int c, logic [7:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic full_seq(int t0);
        push(t0 + 19, mk(4'b0001, 1'b0, 1'b0, 2'd0));
        push(t0 + 41, mk(4'b0011, 1'b0, 1'b0, 2'd0));
        push(t0 + 63, mk(4'b0111, 1'b0, 1'b0, 2'd0));
        push(t0 + 85, mk(4'b1111, 1'b0, 1'b0, 2'd0));
        push(t0 + 91, mk(4'b1111, 1'b1, 1'b0, 2'd0));
    endtask

    task automatic drop();
        int n;
        n = cyc;
        rst_req_n = 1'b0;
        push(n + 3, mk(4'b0000, 1'b0, 1'b0, 2'd0));
        tick(10);
    endtask

    // Monitor: every change of the output bundle must match the next queued event.
    initial begin
        logic [7:0] prev;
        ev_t        e;
        @(negedge clk);
        prev = obs;
        forever begin
            @(negedge clk);
            if (mon_en && obs !== prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%h", cyc, obs);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.val !== obs) begin
                        bad++;
                        $display("FAIL event cyc got=%0d exp=%0d val got=%h exp=%h",
                                 cyc, e.cyc, obs, e.val);
                    end
                end
            end
            prev = obs;
        end
    end

    initial begin
        int t0;
        int n;
        reset     = 1'b1;
        rst_req_n = 1'b1;

        // reset held with request high: everything stays asserted
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("reset_hold", obs, mk(4'b0000, 1'b0, 1'b0, 2'd0));
        end
        reset = 1'b0;
        tick(1);
        chk("reset_after", obs, mk(4'b0000, 1'b0, 1'b0, 2'd0));
        rst_req_n = 1'b0;
        tick(5);
        mon_en = 1'b1;

        // ready follows reset_n after 5 cycles
        mode = 0;
        t0 = cyc;
        rst_req_n = 1'b1;
        full_seq(t0);
        tick(100);
        drop();

        // ready constantly high: 17-cycle spacing
        mode = 1;
        t0 = cyc;
        rst_req_n = 1'b1;
        push(t0 + 19, mk(4'b0001, 1'b0, 1'b0, 2'd0));
        push(t0 + 36, mk(4'b0011, 1'b0, 1'b0, 2'd0));
        push(t0 + 53, mk(4'b0111, 1'b0, 1'b0, 2'd0));
        push(t0 + 70, mk(4'b1111, 1'b0, 1'b0, 2'd0));
        push(t0 + 71, mk(4'b1111, 1'b1, 1'b0, 2'd0));
        tick(80);
        drop();

        // one-cycle request glitch mid-sequence, then restart
        mode = 0;
        t0 = cyc;
        rst_req_n = 1'b1;
        push(t0 + 19, mk(4'b0001, 1'b0, 1'b0, 2'd0));
        push(t0 + 41, mk(4'b0011, 1'b0, 1'b0, 2'd0));
        tick(45);
        n = cyc;
        rst_req_n = 1'b0;
        push(n + 3, mk(4'b0000, 1'b0, 1'b0, 2'd0));
        tick(1);
        t0 = cyc;
        rst_req_n = 1'b1;
        full_seq(t0);
        tick(100);
        drop();

        // stage 2 never ready: timeout fault, then 3-cycle request pulse clears it
        mode = 2;
        t0 = cyc;
        rst_req_n = 1'b1;
        push(t0 + 19, mk(4'b0001, 1'b0, 1'b0, 2'd0));
        push(t0 + 41, mk(4'b0011, 1'b0, 1'b0, 2'd0));
        push(t0 + 63, mk(4'b0111, 1'b0, 1'b0, 2'd0));
        push(t0 + 63 + 1024, mk(4'b0000, 1'b0, 1'b1, 2'd2));
        tick(1100);
        chk("fault_sticky", obs, mk(4'b0000, 1'b0, 1'b1, 2'd2));
        n = cyc;
        rst_req_n = 1'b0;
        mode = 0;
        push(n + 3, mk(4'b0000, 1'b0, 1'b0, 2'd0));
        tick(3);
        t0 = cyc;
        rst_req_n = 1'b1;
        full_seq(t0);
        tick(100);
        chk("done_held", obs, mk(4'b1111, 1'b1, 1'b0, 2'd0));
        drop();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events left=%0d", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
